// File: rtl/uart.sv
// uart: 8N1 receive-to-transmit echo with a small byte FIFO between the two halves
module uart #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RsRx,
    output logic RsTx
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_push;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push, pop;
    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_q, tx_d;

    assign RsTx = tx_q;
    assign push = rx_push && (count_q != FULL);
    assign pop  = (tx_state_q == T_IDLE) && (count_q != '0);

    // Receiver: find the synchronized falling edge, sample mid-bit, push on a good stop bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (prev_q && !sync2_q) rx_state_d = R_START;
            end
            R_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = sync2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_q == CPB_M1) begin
                rx_cnt_d            = '0;
                rx_data_d[rx_bit_q] = sync2_q;
                rx_bit_d            = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            end
            R_STOP: if (rx_cnt_q == CPB_M1) begin
                rx_cnt_d   = '0;
                rx_push    = sync2_q;
                rx_state_d = sync2_q ? R_IDLE : R_WAIT;
            end
            R_WAIT: begin
                rx_cnt_d = '0;
                if (sync2_q) rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // FIFO pointer and occupancy update; a full FIFO silently drops the push
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    // Transmitter: pop in IDLE, then shift start, data LSB first, stop; output is registered
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_d       = tx_q;
        case (tx_state_q)
            T_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (count_q != '0) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_state_d = T_START;
                    tx_d       = 1'b0;
                end
            end
            T_START: if (tx_cnt_q == CPB_M1) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = tx_data_q[0];
                tx_state_d = T_DATA;
            end
            T_DATA: if (tx_cnt_q == CPB_M1) begin
                tx_cnt_d   = '0;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_d       = (tx_bit_q == 3'd7) ? 1'b1 : tx_data_q[tx_bit_q + 3'd1];
                tx_state_d = (tx_bit_q == 3'd7) ? T_STOP : T_DATA;
            end
            T_STOP: if (tx_cnt_q == CPB_M1) begin
                tx_cnt_d   = '0;
                tx_d       = 1'b1;
                tx_state_d = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Byte storage needs no reset; the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data_q;
    end

    // State registers; synchronizer resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            sync1_q    <= RsRx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
            tx_q       <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed echo checks with a 16-clock bit period
module tb_uart;
    localparam int CPB = 16;
    localparam int LAT = 156;
    localparam int GAP = 161;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RsRx = 1'b1;
    logic RsTx;
    int cyc = 0;
    int t0 = 0;
    int checks = 0;
    int errors = 0;
    int fq_start[$];
    logic [7:0] fq_data[$];
    logic fq_stop[$];

    uart #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .RsRx(RsRx), .RsTx(RsTx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decode frames on RsTx by sampling mid-bit on falling clock edges
    initial begin
        int st;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (rst_n && RsTx === 1'b0) begin
                st = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = RsTx;
                end
                repeat (CPB) @(negedge clk);
                fq_start.push_back(st);
                fq_data.push_back(d);
                fq_stop.push_back(RsTx);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        RsRx = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk); #1;
            RsRx = b[i];
        end
        repeat (CPB) @(posedge clk); #1;
        RsRx = stop;
        repeat (CPB) @(posedge clk); #1;
        RsRx = 1'b1;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k = 0;
        while (fq_data.size() < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk(tag, 32'(fq_data.size()), 32'(n));
    endtask

    task automatic clear_q();
        fq_start.delete();
        fq_data.delete();
        fq_stop.delete();
    endtask

    initial begin
        int s0;
        logic [7:0] exp4 [4];
        exp4[0] = 8'h41; exp4[1] = 8'h42; exp4[2] = 8'h31; exp4[3] = 8'h30;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_tx_high", 32'(RsTx), 32'd1);
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("idle_tx_high", 32'(RsTx), 32'd1);
        chk("idle_no_frames", 32'(fq_data.size()), 32'd0);

        send_byte(8'h41, 1'b1);
        wait_frames(1, "single_count");
        chk("single_data", 32'(fq_data[0]), 32'h41);
        chk("single_stop", 32'(fq_stop[0]), 32'd1);
        chk("single_latency", 32'(fq_start[0] - t0), 32'(LAT));
        repeat (50) @(posedge clk);
        clear_q();

        send_byte(exp4[0], 1'b1);
        s0 = t0;
        for (int i = 1; i < 4; i++) send_byte(exp4[i], 1'b1);
        wait_frames(4, "burst_count");
        for (int i = 0; i < 4; i++) chk($sformatf("burst_data%0d", i), 32'(fq_data[i]), 32'(exp4[i]));
        chk("burst_latency", 32'(fq_start[0] - s0), 32'(LAT));
        for (int i = 0; i < 3; i++) chk($sformatf("burst_gap%0d", i), 32'(fq_start[i + 1] - fq_start[i]), 32'(GAP));
        repeat (50) @(posedge clk);
        clear_q();

        @(posedge clk); #1;
        RsRx = 1'b0;
        repeat (6) @(posedge clk); #1;
        RsRx = 1'b1;
        repeat (300) @(posedge clk); #1;
        chk("glitch_no_frame", 32'(fq_data.size()), 32'd0);
        chk("glitch_tx_high", 32'(RsTx), 32'd1);

        send_byte(8'h55, 1'b0);
        repeat (20) @(posedge clk);
        send_byte(8'h30, 1'b1);
        wait_frames(1, "ferr_count");
        chk("ferr_next_data", 32'(fq_data[0]), 32'h30);
        chk("ferr_next_latency", 32'(fq_start[0] - t0), 32'(LAT));
        repeat (50) @(posedge clk);
        clear_q();

        send_byte(8'h42, 1'b1);
        repeat (60) @(posedge clk); #1;
        chk("mid_echo_tx_low", 32'(RsTx), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_mid_tx_high", 32'(RsTx), 32'd1);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (250) @(posedge clk);
        clear_q();
        repeat (300) @(posedge clk);
        chk("post_reset_empty", 32'(fq_data.size()), 32'd0);
        send_byte(8'h31, 1'b1);
        wait_frames(1, "post_reset_count");
        chk("post_reset_data", 32'(fq_data[0]), 32'h31);
        chk("post_reset_latency", 32'(fq_start[0] - t0), 32'(LAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
